// File: rtl/counter_tick_ctrl_if.sv
// Control bundle between the board-side buttons/speed switches and the tick generator.
interface counter_tick_ctrl_if;
  logic       btn_run;
  logic       btn_step;
  logic [1:0] div_sel;
  logic       tick;
  logic       running;

  modport master (output btn_run, btn_step, div_sel, input tick, running);
  modport slave  (input btn_run, btn_step, div_sel, output tick, running);
endinterface

// File: rtl/counter_tick_ctrl.sv
// Debounced run/pause + single-step tick-enable generator for the LED counter.
// Per-button sync/debounce/press-detect lives in counter_tick_ctrl_db.

module counter_tick_ctrl_db #(
  parameter int DB_CYCLES = 250_000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic          stable, stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      press    <= stable & ~stable_q;
      // a level is only accepted after DB_CYCLES consecutive disagreeing samples
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module counter_tick_ctrl #(
  parameter int DIV       = 25_000_000,
  parameter int DB_CYCLES = 250_000
) (
  input logic               sysclk,
  input logic               reset,
  counter_tick_ctrl_if.slave ctl
);
  localparam int NUM_BTN = 2;
  localparam int PW      = $clog2(DIV);

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_press;
  logic               run_press, step_press;
  state_t             state;
  logic [PW-1:0]      pcnt, lim_m1;
  logic               tick_q, running_q;

  assign btn_raw = {ctl.btn_step, ctl.btn_run};

  counter_tick_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
    .sysclk (sysclk),
    .reset  (reset),
    .raw    (btn_raw),
    .press  (btn_press)
  );

  assign run_press  = btn_press[0];
  assign step_press = btn_press[1];

  always_comb lim_m1 = PW'((DIV >> ctl.div_sel) - 1);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state     <= PAUSED;
      pcnt      <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        PAUSED: begin
          pcnt <= '0;
          // run wins over a coincident step
          if (run_press) begin
            state     <= RUNNING;
            running_q <= 1'b1;
          end else if (step_press) begin
            tick_q <= 1'b1;
          end
        end
        RUNNING: begin
          if (run_press) begin
            state     <= PAUSED;
            running_q <= 1'b0;
            pcnt      <= '0;
          end else if (pcnt >= lim_m1) begin
            // >= so a shrinking div_sel wraps at once instead of overrunning
            pcnt   <= '0;
            tick_q <= 1'b1;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: begin
          state     <= PAUSED;
          running_q <= 1'b0;
          pcnt      <= '0;
        end
      endcase
    end
  end

  assign ctl.tick    = tick_q;
  assign ctl.running = running_q;
endmodule
